// File: rtl/data_type_pkg.sv
// Opcode encodings shared by the bf16 arithmetic path and its scheduler.
package data_type_pkg;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;

endpackage

// File: rtl/bf16_op_scheduler.sv
// Sequencing controller for the shared bf16 add/mul path: round-robin grant between two
// requesters, holds operands on the op multiplexer for OP_LAT cycles, then returns the
// captured result, overflow and illegal-opcode flag on a valid/ready response channel.
module bf16_op_scheduler
  import data_type_pkg::*;
#(
  parameter int unsigned OP_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [3:0]  req0_op_i,
  input  logic [15:0] req0_in1_i,
  input  logic [15:0] req0_in2_i,

  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [3:0]  req1_op_i,
  input  logic [15:0] req1_in1_i,
  input  logic [15:0] req1_in2_i,

  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [15:0] rsp_data_o,
  output logic        rsp_overflow_o,
  output logic        rsp_illegal_o,

  output logic [3:0]  mux_op_o,
  output logic [15:0] mux_in1_o,
  output logic [15:0] mux_in2_o,
  input  logic [15:0] mux_out_i,
  input  logic        mux_overflow_i,

  output logic        busy_o
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [3:0] CntInit = 4'(OP_LAT - 1);

  state_e      state_q;
  logic        prio_q;
  logic [3:0]  cnt_q;
  logic [3:0]  op_q;
  logic [15:0] in1_q;
  logic [15:0] in2_q;
  logic        id_q;
  logic [15:0] data_q;
  logic        ovf_q;
  logic        illegal_q;

  logic        gnt_valid;
  logic        gnt_id;
  logic [3:0]  gnt_op;
  logic [15:0] gnt_in1;
  logic [15:0] gnt_in2;
  logic        gnt_legal;
  logic        accept;

  // Grant: a lone valid wins, otherwise the priority pointer decides. Readies stay low in reset.
  always_comb begin
    gnt_valid = req0_valid_i | req1_valid_i;
    gnt_id    = (req0_valid_i & req1_valid_i) ? prio_q : req1_valid_i;
    gnt_op    = gnt_id ? req1_op_i  : req0_op_i;
    gnt_in1   = gnt_id ? req1_in1_i : req0_in1_i;
    gnt_in2   = gnt_id ? req1_in2_i : req0_in2_i;
    gnt_legal = (gnt_op == OP_ADD) || (gnt_op == OP_MUL);
    accept    = (state_q == StIdle) && !rst && gnt_valid;
  end

  assign req0_ready_o   = accept & ~gnt_id;
  assign req1_ready_o   = accept & gnt_id;

  assign rsp_valid_o    = (state_q == StResp);
  assign rsp_id_o       = id_q;
  assign rsp_data_o     = data_q;
  assign rsp_overflow_o = ovf_q;
  assign rsp_illegal_o  = illegal_q;

  assign mux_op_o       = op_q;
  assign mux_in1_o      = in1_q;
  assign mux_in2_o      = in2_q;

  assign busy_o         = (state_q != StIdle);

  // Controller FSM with the operand, result and arbitration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      prio_q    <= 1'b0;
      cnt_q     <= 4'd0;
      op_q      <= 4'd0;
      in1_q     <= 16'd0;
      in2_q     <= 16'd0;
      id_q      <= 1'b0;
      data_q    <= 16'd0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q   <= gnt_op;
            in1_q  <= gnt_in1;
            in2_q  <= gnt_in2;
            id_q   <= gnt_id;
            prio_q <= ~gnt_id;
            if (gnt_legal) begin
              cnt_q   <= CntInit;
              state_q <= StExec;
            end else begin
              // Illegal opcodes never touch the datapath; answer right away.
              data_q    <= 16'd0;
              ovf_q     <= 1'b0;
              illegal_q <= 1'b1;
              state_q   <= StResp;
            end
          end
        end
        StExec: begin
          if (cnt_q == 4'd0) begin
            data_q    <= mux_out_i;
            ovf_q     <= mux_overflow_i;
            illegal_q <= 1'b0;
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_op_scheduler.sv
// Self-checking bench for bf16_op_scheduler: directed scenarios with literal expectations,
// then randomized traffic, all shadowed by a transaction-level model checked every cycle.
module tb_bf16_op_scheduler;
  import data_type_pkg::*;

  localparam int unsigned Lat = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic        req0_ready_o, req1_ready_o;
  logic [3:0]  req0_op_i = '0, req1_op_i = '0;
  logic [15:0] req0_in1_i = '0, req0_in2_i = '0, req1_in1_i = '0, req1_in2_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_id_o, rsp_overflow_o, rsp_illegal_o;
  logic [15:0] rsp_data_o;
  logic [3:0]  mux_op_o;
  logic [15:0] mux_in1_o, mux_in2_o, mux_out_i;
  logic        mux_overflow_i, busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bf16_op_scheduler #(.OP_LAT(Lat)) dut (
    .clk            (clk),
    .rst            (rst),
    .req0_valid_i   (req0_valid_i),
    .req0_ready_o   (req0_ready_o),
    .req0_op_i      (req0_op_i),
    .req0_in1_i     (req0_in1_i),
    .req0_in2_i     (req0_in2_i),
    .req1_valid_i   (req1_valid_i),
    .req1_ready_o   (req1_ready_o),
    .req1_op_i      (req1_op_i),
    .req1_in1_i     (req1_in1_i),
    .req1_in2_i     (req1_in2_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_id_o       (rsp_id_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_overflow_o (rsp_overflow_o),
    .rsp_illegal_o  (rsp_illegal_o),
    .mux_op_o       (mux_op_o),
    .mux_in1_o      (mux_in1_o),
    .mux_in2_o      (mux_in2_o),
    .mux_out_i      (mux_out_i),
    .mux_overflow_i (mux_overflow_i),
    .busy_o         (busy_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Stand-in arithmetic unit, returns {overflow, data}. Real bf16 results for the directed
  // vectors, an arbitrary mix otherwise (the scheduler only passes values through).
  function automatic logic [16:0] unit_f(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    if (op == OP_ADD && a == 16'h3F80 && b == 16'h4000) return {1'b0, 16'h4040};
    if (op == OP_MUL && a == 16'h4000 && b == 16'h4040) return {1'b0, 16'h40C0};
    if (op == OP_MUL && a == 16'h7F00 && b == 16'h7F00) return {1'b1, 16'h7F80};
    return {^(a & b), a ^ {b[7:0], b[15:8]} ^ {12'h0, op}};
  endfunction

  // The unit's output is only correct once its inputs have been steady for Lat-1 edges;
  // before that it shows the inverted value, so an early capture is visible.
  int          stable = 0;
  logic [35:0] mux_prev = '0;
  always @(negedge clk) begin
    if ({mux_op_o, mux_in1_o, mux_in2_o} != mux_prev) stable = 0;
    else if (stable < 1000) stable++;
    mux_prev = {mux_op_o, mux_in1_o, mux_in2_o};
  end
  assign {mux_overflow_i, mux_out_i} = (stable >= int'(Lat) - 1) ?
      unit_f(mux_op_o, mux_in1_o, mux_in2_o) : ~unit_f(mux_op_o, mux_in1_o, mux_in2_o);

  // Transaction-level model: at most one transaction in flight, a response becomes visible
  // a fixed number of cycles after acceptance and stays until consumed.
  bit          m_have = 0;
  bit          m_id = 0;
  bit          m_prio = 0;
  bit          m_ill = 0;
  int          m_wait = 0;
  logic [3:0]  m_op = '0;
  logic [15:0] m_a = '0, m_b = '0;
  logic [16:0] m_res = '0;

  always @(negedge clk) begin
    bit g_v, g_id;
    if (rst) begin
      chk("reset_outputs", {req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o,
          rsp_overflow_o, rsp_illegal_o, mux_op_o, mux_in1_o, mux_in2_o, busy_o}, 64'd0);
      m_have = 0; m_prio = 0; m_op = '0; m_a = '0; m_b = '0; m_wait = 0;
    end else begin
      g_v  = req0_valid_i || req1_valid_i;
      g_id = (req0_valid_i && req1_valid_i) ? m_prio : req1_valid_i;
      chk("ready0", req0_ready_o, !m_have && g_v && !g_id);
      chk("ready1", req1_ready_o, !m_have && g_v && g_id);
      chk("one_ready", req0_ready_o & req1_ready_o, 1'b0);
      chk("busy", busy_o, m_have);
      chk("rsp_valid", rsp_valid_o, m_have && m_wait == 0);
      chk("mux_drive", {mux_op_o, mux_in1_o, mux_in2_o}, {m_op, m_a, m_b});
      if (m_have && m_wait == 0)
        chk("rsp_payload", {rsp_id_o, rsp_data_o, rsp_overflow_o, rsp_illegal_o},
            {m_id, m_ill ? 17'd0 : {m_res[15:0], m_res[16]}, m_ill});
      if (!m_have) begin
        if (g_v) begin
          m_have = 1;
          m_id   = g_id;
          m_prio = !g_id;
          m_op   = g_id ? req1_op_i  : req0_op_i;
          m_a    = g_id ? req1_in1_i : req0_in1_i;
          m_b    = g_id ? req1_in2_i : req0_in2_i;
          m_ill  = !(m_op == OP_ADD || m_op == OP_MUL);
          m_res  = unit_f(m_op, m_a, m_b);
          m_wait = m_ill ? 0 : int'(Lat);
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (rsp_ready_i) begin
        m_have = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input bit v, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    if (id) begin
      req1_valid_i = v; req1_op_i = op; req1_in1_i = a; req1_in2_i = b;
    end else begin
      req0_valid_i = v; req0_op_i = op; req0_in1_i = a; req0_in2_i = b;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (busy_o && g < 100) begin tick(); g++; end
    if (g >= 100) timeout("drain");
  endtask

  // One request end to end; returns the number of cycles from acceptance to rsp_valid_o.
  task automatic run_one(input bit id, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, output int lat);
    int n;
    drive(id, 1'b1, op, a, b);
    #1;
    n = 0;
    while (!(id ? req1_ready_o : req0_ready_o) && n < 50) begin tick(); n++; end
    if (n >= 50) timeout("grant");
    tick();
    drive(id, 1'b0, op, a, b);
    #1;
    lat = 1;
    while (!rsp_valid_o && lat < 50) begin
      chk("exec_operands", {mux_op_o, mux_in1_o, mux_in2_o}, {op, a, b});
      tick();
      lat++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, guard, n0, n1;
    bit a0, a1, ids[$];
    bit exp_ids[8];
    exp_ids = '{0, 1, 0, 1, 0, 1, 0, 1};

    // Reset with both valids up: every output, readies included, must be 0.
    req0_valid_i = 1'b1;
    req1_valid_i = 1'b1;
    tick();
    chk("reset_all_zero", {req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o,
        rsp_overflow_o, rsp_illegal_o, mux_op_o, mux_in1_o, mux_in2_o, busy_o}, 64'd0);
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("idle_no_ready", {req0_ready_o, req1_ready_o, busy_o}, 3'b000);

    // Add on requester 0.
    rsp_ready_i = 1'b1;
    run_one(1'b0, OP_ADD, 16'h3F80, 16'h4000, lat);
    chk("add_latency", lat, Lat + 1);
    chk("add_rsp", {rsp_valid_o, rsp_id_o, rsp_data_o, rsp_overflow_o, rsp_illegal_o},
        {1'b1, 1'b0, 16'h4040, 1'b0, 1'b0});
    tick();
    chk("add_busy_after", busy_o, 1'b0);

    // Mul on requester 1.
    run_one(1'b1, OP_MUL, 16'h4000, 16'h4040, lat);
    chk("mul_rsp", {rsp_id_o, rsp_data_o, rsp_illegal_o}, {1'b1, 16'h40C0, 1'b0});
    tick();

    // Illegal opcode answers one cycle after acceptance.
    run_one(1'b0, 4'hF, 16'h1234, 16'h5678, lat);
    chk("illegal_latency", lat, 1);
    chk("illegal_rsp", {rsp_data_o, rsp_overflow_o, rsp_illegal_o}, {16'h0, 1'b0, 1'b1});
    tick();

    // Overflow passes straight from the unit.
    run_one(1'b1, OP_MUL, 16'h7F00, 16'h7F00, lat);
    chk("ovf_rsp", {rsp_data_o, rsp_overflow_o, rsp_illegal_o}, {16'h7F80, 1'b1, 1'b0});
    tick();

    // Back-pressure: response held 5 cycles with a pending request on requester 1.
    rsp_ready_i = 1'b0;
    run_one(1'b0, OP_ADD, 16'h3F80, 16'h4000, lat);
    chk("bp_latency", lat, Lat + 1);
    drive(1'b1, 1'b1, OP_MUL, 16'h4000, 16'h4040);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_stable", {rsp_valid_o, rsp_id_o, rsp_data_o, rsp_overflow_o, rsp_illegal_o},
          {1'b1, 1'b0, 16'h4040, 1'b0, 1'b0});
      chk("bp_no_ready", {req0_ready_o, req1_ready_o}, 2'b00);
      tick();
    end
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_no_ready_hs", {req0_ready_o, req1_ready_o}, 2'b00);
    tick();
    chk("bp_ready_after_hs", {req0_ready_o, req1_ready_o}, 2'b01);
    tick();
    drive(1'b1, 1'b0, OP_MUL, 16'h4000, 16'h4040);
    drain();

    // Reset in the second EXEC cycle aborts the transaction.
    run_one_abort: begin
      drive(1'b0, 1'b1, OP_ADD, 16'h3F80, 16'h4000);
      #1;
      chk("abort_ready", req0_ready_o, 1'b1);
      tick();
      drive(1'b0, 1'b0, OP_ADD, 16'h3F80, 16'h4000);
      tick();
      rst = 1'b1;
      #1;
      chk("abort_zero", {req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o,
          rsp_overflow_o, rsp_illegal_o, mux_op_o, mux_in1_o, mux_in2_o, busy_o}, 64'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < int'(Lat) + 3; i++) begin
        tick();
        chk("abort_no_rsp", {rsp_valid_o, busy_o}, 2'b00);
      end
    end
    run_one(1'b1, OP_MUL, 16'h4000, 16'h4040, lat);
    chk("post_abort_latency", lat, Lat + 1);
    chk("post_abort_rsp", {rsp_id_o, rsp_data_o}, {1'b1, 16'h40C0});
    tick();

    // Contention from reset: both requesters keep 4 requests each queued.
    reset_dut();
    drive(1'b0, 1'b1, OP_ADD, 16'($urandom), 16'($urandom));
    drive(1'b1, 1'b1, OP_MUL, 16'($urandom), 16'($urandom));
    n0 = 0; n1 = 0; guard = 0;
    while (ids.size() < 8 && guard < 400) begin
      #1;
      a0 = req0_valid_i && req0_ready_o;
      a1 = req1_valid_i && req1_ready_o;
      if (rsp_valid_o && rsp_ready_i) ids.push_back(rsp_id_o);
      tick();
      if (a0) begin n0++; drive(1'b0, n0 < 4, OP_ADD, 16'($urandom), 16'($urandom)); end
      if (a1) begin n1++; drive(1'b1, n1 < 4, OP_MUL, 16'($urandom), 16'($urandom)); end
      guard++;
    end
    if (ids.size() < 8) timeout("contention");
    else for (int i = 0; i < 8; i++) chk("contention_id", ids[i], exp_ids[i]);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a0 = req0_valid_i && req0_ready_o;
      a1 = req1_valid_i && req1_ready_o;
      tick();
      for (int r = 0; r < 2; r++) begin
        bit acc, v;
        logic [3:0] op;
        acc = (r == 0) ? a0 : a1;
        v   = (r == 0) ? req0_valid_i : req1_valid_i;
        op  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ($urandom_range(0, 1) ? OP_ADD : OP_MUL);
        if (acc || !v) begin
          if ($urandom_range(0, 99) < (acc ? 70 : 35))
            drive(r[0], 1'b1, op, 16'($urandom), 16'($urandom));
          else
            drive(r[0], 1'b0, op, 16'($urandom), 16'($urandom));
        end else if ($urandom_range(0, 99) < 8) begin
          if (r == 0) req0_valid_i = 1'b0;
          else        req1_valid_i = 1'b0;
        end
      end
      rsp_ready_i = ($urandom_range(0, 99) < 60);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf16_op_scheduler.md
# bf16_op_scheduler

Sequencing controller for the shared bfloat16 arithmetic path, which is the op multiplexer feeding the add and mul units. It arbitrates round-robin between two requesters and issues one operation at a time. It holds the operands stable for a programmable settle time, captures the result and overflow flag, and returns them with a requester ID over a valid/ready response channel. Opcodes `OP_ADD` and `OP_MUL` come from `data_type_pkg`; any other opcode is rejected as illegal.

## Interface
Parameters:
- `OP_LAT`, default 1: cycles the datapath is held in EXEC before the result is captured. Legal range is 1..15.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid_i` in 1: requester 0 has a request.
- `req0_ready_o` out 1: request 0 accepted this cycle.
- `req0_op_i` in 4: opcode.
- `req0_in1_i` in 16: bf16 operand 1.
- `req0_in2_i` in 16: bf16 operand 2.
- `req1_valid_i`, `req1_ready_o`, `req1_op_i`, `req1_in1_i`, `req1_in2_i`: same as requester 0, for requester 1.
- `rsp_valid_o` out 1: response available.
- `rsp_ready_i` in 1: consumer takes the response.
- `rsp_id_o` out 1: requester index of the response.
- `rsp_data_o` out 16: bf16 result.
- `rsp_overflow_o` out 1: overflow flag from the unit.
- `rsp_illegal_o` out 1: opcode was not `OP_ADD` or `OP_MUL`.
- `mux_op_o` out 4: opcode driven to the op multiplexer.
- `mux_in1_o` out 16: operand 1 driven to the op multiplexer.
- `mux_in2_o` out 16: operand 2 driven to the op multiplexer.
- `mux_out_i` in 16: result from the op multiplexer.
- `mux_overflow_i` in 1: overflow from the op multiplexer.
- `busy_o` out 1: high whenever state is not IDLE.

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE:** grant is computed combinationally from the two valids and the priority pointer `prio`.
  - If only one requester is valid, it is granted.
  - If both are valid, requester `prio` is granted.
  - `reqN_ready_o` = (state==IDLE) && granted==N. At most one ready is high per cycle.
- **On acceptance (valid && ready):**
  - Latch op, in1, in2 and id into registers.
  - Set `prio` to the opposite of the granted index.
  - If the op is legal, go to EXEC and load `cnt` = OP_LAT-1.
  - If the op is illegal, go straight to RESP with data=0, overflow=0, illegal=1.
- **EXEC:** decrement `cnt` each cycle. In the cycle where `cnt`==0:
  - Capture `mux_out_i` into the data register.
  - Capture `mux_overflow_i` into the overflow register.
  - Clear the illegal register and go to RESP.
- **RESP:** `rsp_valid_o` = 1. When `rsp_ready_i` is high, go to IDLE.
- **Datapath outputs:** `mux_op_o`, `mux_in1_o` and `mux_in2_o` always drive the latched registers. They are stable throughout EXEC and change only on acceptance.
- **Requester rule:** a requester holds its payload stable while valid && !ready. A requester may deassert valid before it is granted; no request is lost or duplicated.
- **Response stability:** all `rsp_*` outputs are stable while `rsp_valid_o` && !`rsp_ready_i`.
- **Pass-through:** no arithmetic is performed in this block. The data and overflow values are passed through unmodified.

## Timing
- **Reset values:** state=IDLE, prio=0, cnt=0. All registers are 0, so every output is 0, including `mux_op_o`, `rsp_valid_o`, `busy_o` and both readies.
  - Both readies go high only after reset deasserts, gated by the valids.
- **Legal-op latency:** acceptance at cycle t → EXEC for cycles t+1 .. t+OP_LAT → `rsp_valid_o` high from cycle t+OP_LAT+1.
- **Illegal-op latency:** acceptance at cycle t → `rsp_valid_o` high at cycle t+1.
- **Response handshake:** completes at cycle u → IDLE at cycle u+1. The earliest next acceptance is cycle u+1.
- **Throughput:** one legal op per OP_LAT+2 cycles with no back-pressure.
- **Held response:** the response may be held indefinitely. No new request is accepted until it is consumed.
- **Reset mid-operation:** the asynchronous `rst` aborts any in-flight transaction with no response. Outputs return to reset values immediately. `prio` returns to 0.
- **Unchanged valids:** `req0_valid_i` and `req1_valid_i` arriving or holding in EXEC or RESP do not change state. Grant is evaluated only in IDLE.

## Test plan
- **Add, requester 0, OP_LAT=1:** accept `OP_ADD`, in1=0x3F80, in2=0x4000 at cycle 0 with `rsp_ready_i`=1.
  - `rsp_valid_o` at cycle 2 with data=0x4040, id=0, overflow=0, illegal=0.
  - `busy_o` low at cycle 3.
- **Mul, requester 1:** `OP_MUL`, in1=0x4000, in2=0x4040.
  - Response data=0x40C0, id=1.
  - `mux_in1_o` and `mux_in2_o` hold 0x4000 and 0x4040 through EXEC.
- **Contention:** both requesters valid continuously with 4 requests each.
  - Grants alternate 0,1,0,1…, starting with 0 after reset.
  - The response id sequence matches. At most one ready is high per cycle.
- **Back-pressure, OP_LAT=3:** hold `rsp_ready_i`=0 for 5 cycles after `rsp_valid_o` rises.
  - The response is stable, and neither ready asserts.
  - Ready first reasserts the cycle after the handshake.
  - Accept-to-valid is 4 cycles.
- **Illegal op and overflow:**
  - opcode 4'hF → response one cycle after acceptance with data=0, illegal=1.
  - `OP_MUL` with 0x7F00 × 0x7F00 → `rsp_overflow_o` equals the unit's `mux_overflow_i`, which is 1.
- **Reset mid-EXEC, OP_LAT=4:** assert `rst` in the second EXEC cycle.
  - All outputs go to 0 immediately, and no response follows.
  - After release, a new request from requester 1 alone is accepted and completes normally.
